// File: rtl/wb_decoder_pkg.sv
// rtl/wb_decoder_pkg.sv - shared types and constants for the Wishbone address decoder
//
// Contents:
//   state_e   : decoder FSM states (IDLE, ACTIVE, RESP)
//   ERR_DATA  : read data returned on unmapped accesses and timeouts
//   ERR_CNT_W : width of the saturating error counter
package wb_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
    localparam int          ERR_CNT_W = 16;

endpackage

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - wait-cycle counter that flags a peripheral ack timeout
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero the counter (held while the decoder is not waiting)
//   enable   : count one wait cycle per clock
//   expired  : high during the TIMEOUT-th enabled cycle
module wb_timeout_cnt
    import wb_decoder_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The count holds the number of completed wait cycles, so the
    // TIMEOUT-th wait cycle is the one where it reads TIMEOUT-1.
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/wb_decoder.sv
// rtl/wb_decoder.sv - one-master to NUM_PERIPH-slave Wishbone address decoder
//
// Ports:
//   io_wbs_clk, io_wbs_rst  : clock and synchronous active-high reset
//   io_wbs_adr/datwr/sel/we/stb/cyc : master request
//   io_wbs_datrd/ack/err    : master response (err qualifies ack)
//   io_wbs_*_p              : flattened peripheral ports, port p at slice p
//   err_count               : saturating count of error responses
module wb_decoder
    import wb_decoder_pkg::*;
#(
    parameter int NUM_PERIPH = 4,
    parameter int SEL_LSB    = 24,
    parameter int TIMEOUT    = 255
) (
    input  logic                      io_wbs_clk,
    input  logic                      io_wbs_rst,
    input  logic [31:0]               io_wbs_adr,
    input  logic [31:0]               io_wbs_datwr,
    input  logic [3:0]                io_wbs_sel,
    input  logic                      io_wbs_we,
    input  logic                      io_wbs_stb,
    input  logic                      io_wbs_cyc,
    output logic [31:0]               io_wbs_datrd,
    output logic                      io_wbs_ack,
    output logic                      io_wbs_err,
    output logic [NUM_PERIPH*32-1:0]  io_wbs_adr_p,
    output logic [NUM_PERIPH*32-1:0]  io_wbs_datwr_p,
    output logic [NUM_PERIPH*4-1:0]   io_wbs_sel_p,
    output logic [NUM_PERIPH-1:0]     io_wbs_we_p,
    output logic [NUM_PERIPH-1:0]     io_wbs_stb_p,
    output logic [NUM_PERIPH-1:0]     io_wbs_cyc_p,
    input  logic [NUM_PERIPH*32-1:0]  io_wbs_datrd_p,
    input  logic [NUM_PERIPH-1:0]     io_wbs_ack_p,
    output logic [ERR_CNT_W-1:0]      err_count
);

    localparam int              SELW = $clog2(NUM_PERIPH);
    localparam logic [SELW:0]   NP   = (SELW + 1)'(NUM_PERIPH);

    state_e                 state_q, state_d;
    logic [31:0]            adr_q, adr_d;
    logic [31:0]            datwr_q, datwr_d;
    logic [3:0]             sel_q, sel_d;
    logic                   we_q, we_d;
    logic [SELW-1:0]        idx_q, idx_d;
    logic [NUM_PERIPH-1:0]  req_q, req_d;
    logic [31:0]            datrd_q, datrd_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

    logic [SELW-1:0]        req_idx;
    logic                   req_mapped;
    logic [NUM_PERIPH-1:0]  req_onehot;
    logic                   sel_ack;
    logic [31:0]            sel_dat;
    logic                   tmo_expired;
    logic [ERR_CNT_W-1:0]   err_count_inc;

    assign req_idx       = io_wbs_adr[SEL_LSB +: SELW];
    assign req_mapped    = ({1'b0, req_idx} < NP);
    assign err_count_inc = (err_count_q == '1) ? err_count_q
                                               : err_count_q + ERR_CNT_W'(1);

    // Only the latched target port's ack/data are looked at; acks from
    // any other port are dropped here.
    always_comb begin
        sel_ack    = 1'b0;
        sel_dat    = '0;
        req_onehot = '0;
        for (int p = 0; p < NUM_PERIPH; p++) begin
            if (idx_q == SELW'(p)) begin
                sel_ack = io_wbs_ack_p[p];
                sel_dat = io_wbs_datrd_p[p*32 +: 32];
            end
            if (req_idx == SELW'(p)) begin
                req_onehot[p] = 1'b1;
            end
        end
    end

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (io_wbs_clk),
        .rst     (io_wbs_rst),
        .clear   (state_q != ST_ACTIVE),
        .enable  (state_q == ST_ACTIVE),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        datwr_d     = datwr_q;
        sel_d       = sel_q;
        we_d        = we_q;
        idx_d       = idx_q;
        req_d       = req_q;
        datrd_d     = datrd_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        case (state_q)
            ST_IDLE: begin
                if (io_wbs_cyc && io_wbs_stb) begin
                    adr_d   = io_wbs_adr;
                    datwr_d = io_wbs_datwr;
                    sel_d   = io_wbs_sel;
                    we_d    = io_wbs_we;
                    idx_d   = req_idx;
                    if (req_mapped) begin
                        state_d = ST_ACTIVE;
                        req_d   = req_onehot;
                    end else begin
                        state_d     = ST_RESP;
                        datrd_d     = ERR_DATA;
                        ack_d       = 1'b1;
                        err_d       = 1'b1;
                        err_count_d = err_count_inc;
                    end
                end
            end
            ST_ACTIVE: begin
                // Abort outranks ack and timeout: the master no longer
                // wants a response. Ack outranks a same-cycle timeout.
                if (!io_wbs_cyc) begin
                    state_d = ST_IDLE;
                    req_d   = '0;
                end else if (sel_ack) begin
                    state_d = ST_RESP;
                    req_d   = '0;
                    datrd_d = sel_dat;
                    ack_d   = 1'b1;
                end else if (tmo_expired) begin
                    state_d     = ST_RESP;
                    req_d       = '0;
                    datrd_d     = ERR_DATA;
                    ack_d       = 1'b1;
                    err_d       = 1'b1;
                    err_count_d = err_count_inc;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            datwr_q     <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            req_q       <= '0;
            datrd_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            datwr_q     <= datwr_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            req_q       <= req_d;
            datrd_q     <= datrd_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // Latched request fields go to every slice; only the selected port
    // sees stb/cyc, so the others ignore them.
    assign io_wbs_adr_p   = {NUM_PERIPH{adr_q}};
    assign io_wbs_datwr_p = {NUM_PERIPH{datwr_q}};
    assign io_wbs_sel_p   = {NUM_PERIPH{sel_q}};
    assign io_wbs_we_p    = {NUM_PERIPH{we_q}};
    assign io_wbs_stb_p   = req_q;
    assign io_wbs_cyc_p   = req_q;
    assign io_wbs_datrd   = datrd_q;
    assign io_wbs_ack     = ack_q;
    assign io_wbs_err     = err_q;
    assign err_count      = err_count_q;

endmodule

// File: tb/tb_wb_decoder.sv
// tb/tb_wb_decoder.sv - self-checking bench for wb_decoder (4-port and 3-port instances)
module tb_wb_decoder;

    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;
    localparam int          TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // master side, index 0 = 4-port instance, 1 = 3-port instance
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_stb [2];
    logic        m_cyc [2];
    logic [31:0] s_datrd [2];
    logic        s_ack [2];
    logic        s_err [2];
    logic [15:0] s_cnt [2];

    logic [127:0] p0_adr, p0_datwr, p0_datrd;
    logic [15:0]  p0_sel;
    logic [3:0]   p0_we, p0_stb, p0_cyc, p0_ack;
    logic [95:0]  p1_adr, p1_datwr, p1_datrd;
    logic [11:0]  p1_sel;
    logic [2:0]   p1_we, p1_stb, p1_cyc, p1_ack;

    wb_decoder #(.NUM_PERIPH(4), .SEL_LSB(24), .TIMEOUT(TMO)) dut0 (
        .io_wbs_clk(clk), .io_wbs_rst(rst),
        .io_wbs_adr(m_adr[0]), .io_wbs_datwr(m_dat[0]), .io_wbs_sel(m_sel[0]),
        .io_wbs_we(m_we[0]), .io_wbs_stb(m_stb[0]), .io_wbs_cyc(m_cyc[0]),
        .io_wbs_datrd(s_datrd[0]), .io_wbs_ack(s_ack[0]), .io_wbs_err(s_err[0]),
        .io_wbs_adr_p(p0_adr), .io_wbs_datwr_p(p0_datwr), .io_wbs_sel_p(p0_sel),
        .io_wbs_we_p(p0_we), .io_wbs_stb_p(p0_stb), .io_wbs_cyc_p(p0_cyc),
        .io_wbs_datrd_p(p0_datrd), .io_wbs_ack_p(p0_ack), .err_count(s_cnt[0])
    );

    wb_decoder #(.NUM_PERIPH(3), .SEL_LSB(24), .TIMEOUT(TMO)) dut1 (
        .io_wbs_clk(clk), .io_wbs_rst(rst),
        .io_wbs_adr(m_adr[1]), .io_wbs_datwr(m_dat[1]), .io_wbs_sel(m_sel[1]),
        .io_wbs_we(m_we[1]), .io_wbs_stb(m_stb[1]), .io_wbs_cyc(m_cyc[1]),
        .io_wbs_datrd(s_datrd[1]), .io_wbs_ack(s_ack[1]), .io_wbs_err(s_err[1]),
        .io_wbs_adr_p(p1_adr), .io_wbs_datwr_p(p1_datwr), .io_wbs_sel_p(p1_sel),
        .io_wbs_we_p(p1_we), .io_wbs_stb_p(p1_stb), .io_wbs_cyc_p(p1_cyc),
        .io_wbs_datrd_p(p1_datrd), .io_wbs_ack_p(p1_ack), .err_count(s_cnt[1])
    );

    function automatic logic [3:0] get_stb(int d);
        return (d == 0) ? p0_stb : {1'b0, p1_stb};
    endfunction
    function automatic logic [3:0] get_cyc(int d);
        return (d == 0) ? p0_cyc : {1'b0, p1_cyc};
    endfunction
    function automatic logic get_ack(int d, int p);
        return (d == 0) ? p0_ack[p[1:0]] : p1_ack[p[1:0]];
    endfunction
    function automatic logic [31:0] get_dat(int d, int p);
        return (d == 0) ? p0_datrd[p*32 +: 32] : p1_datrd[p*32 +: 32];
    endfunction
    function automatic logic [31:0] get_padr(int d, int p);
        return (d == 0) ? p0_adr[p*32 +: 32] : p1_adr[p*32 +: 32];
    endfunction
    function automatic logic [31:0] get_pwr(int d, int p);
        return (d == 0) ? p0_datwr[p*32 +: 32] : p1_datwr[p*32 +: 32];
    endfunction
    function automatic logic [3:0] get_psel(int d, int p);
        return (d == 0) ? p0_sel[p*4 +: 4] : p1_sel[p*4 +: 4];
    endfunction
    function automatic logic get_pwe(int d, int p);
        return (d == 0) ? p0_we[p[1:0]] : p1_we[p[1:0]];
    endfunction

    task automatic check(string nm, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = no transfer, 1 = waiting on the
    // peripheral (waited = cycles spent), 2 = response cycle.
    int          ph [2];
    int          port [2];
    int          waited [2];
    int          e_cnt [2];
    logic [31:0] e_adr [2];
    logic [31:0] e_dat [2];
    logic [3:0]  e_sel [2];
    logic        e_we [2];
    logic [3:0]  e_stb [2];
    logic        e_ack [2];
    logic        e_err [2];
    logic [31:0] e_datrd [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                ph[d] = 0; e_cnt[d] = 0; e_adr[d] = '0; e_dat[d] = '0;
                e_sel[d] = '0; e_we[d] = 1'b0; e_stb[d] = '0;
                e_ack[d] = 1'b0; e_err[d] = 1'b0; e_datrd[d] = '0;
            end else begin
                e_ack[d] = 1'b0;
                e_err[d] = 1'b0;
                if (ph[d] == 1) begin
                    waited[d]++;
                    if (!m_cyc[d]) begin
                        ph[d] = 0; e_stb[d] = '0;
                    end else if (get_ack(d, port[d])) begin
                        ph[d] = 2; e_stb[d] = '0; e_ack[d] = 1'b1;
                        e_datrd[d] = get_dat(d, port[d]);
                    end else if (waited[d] == TMO) begin
                        ph[d] = 2; e_stb[d] = '0; e_ack[d] = 1'b1; e_err[d] = 1'b1;
                        e_datrd[d] = DEAD;
                        if (e_cnt[d] < 65535) e_cnt[d]++;
                    end
                end else if (ph[d] == 2) begin
                    ph[d] = 0;
                end else if (m_cyc[d] && m_stb[d]) begin
                    e_adr[d] = m_adr[d]; e_dat[d] = m_dat[d];
                    e_sel[d] = m_sel[d]; e_we[d] = m_we[d];
                    port[d] = int'(m_adr[d][25:24]);
                    if (port[d] < ((d == 0) ? 4 : 3)) begin
                        ph[d] = 1; waited[d] = 0; e_stb[d] = 4'(1 << port[d]);
                    end else begin
                        ph[d] = 2; e_ack[d] = 1'b1; e_err[d] = 1'b1; e_datrd[d] = DEAD;
                        if (e_cnt[d] < 65535) e_cnt[d]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check("m_ack", d, 32'(s_ack[d]), 32'(e_ack[d]));
            check("m_err", d, 32'(s_err[d]), 32'(e_err[d]));
            check("m_datrd", d, s_datrd[d], e_datrd[d]);
            check("m_errcnt", d, 32'(s_cnt[d]), 32'(e_cnt[d]));
            check("m_stb_p", d, 32'(get_stb(d)), 32'(e_stb[d]));
            check("m_cyc_p", d, 32'(get_cyc(d)), 32'(e_stb[d]));
            if (e_stb[d] != 4'd0) begin
                check("m_adr_p", d, get_padr(d, port[d]), e_adr[d]);
                check("m_datwr_p", d, get_pwr(d, port[d]), e_dat[d]);
                check("m_sel_p", d, 32'(get_psel(d, port[d])), 32'(e_sel[d]));
                check("m_we_p", d, 32'(get_pwe(d, port[d])), 32'(e_we[d]));
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic req(int d, logic [31:0] a, logic [31:0] w, logic we);
        m_adr[d] = a; m_dat[d] = w; m_sel[d] = 4'hF; m_we[d] = we;
        m_cyc[d] = 1'b1; m_stb[d] = 1'b1;
    endtask

    task automatic idle(int d);
        m_cyc[d] = 1'b0; m_stb[d] = 1'b0;
    endtask

    task automatic pack(int d, int p, logic v, logic [31:0] dat);
        if (d == 0) begin
            p0_ack[p[1:0]] = v; p0_datrd[p*32 +: 32] = dat;
        end else begin
            p1_ack[p[1:0]] = v; p1_datrd[p*32 +: 32] = dat;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_adr[d] = '0; m_dat[d] = '0; m_sel[d] = '0; m_we[d] = 1'b0;
            idle(d);
        end
        p0_ack = '0; p0_datrd = '0; p1_ack = '0; p1_datrd = '0;
        tick(2);
        rst = 1'b0;
        check("rst_ack", 0, 32'(s_ack[0]), 32'd0);
        check("rst_datrd", 0, s_datrd[0], 32'd0);
        check("rst_stb", 0, 32'(get_stb(0)), 32'd0);
        check("rst_adr_slice0", 0, p0_adr[31:0], 32'd0);

        // zero-wait write to peripheral 2
        req(0, 32'h0200_0010, 32'h1234_5678, 1'b1);
        tick(1);
        check("t1_stb_only2", 0, 32'(get_stb(0)), 32'h4);
        check("t1_adr_slice2", 0, p0_adr[95:64], 32'h0200_0010);
        check("t1_dat_slice2", 0, p0_datwr[95:64], 32'h1234_5678);
        check("t1_no_ack_yet", 0, 32'(s_ack[0]), 32'd0);
        pack(0, 2, 1'b1, 32'h0);
        tick(1);
        check("t1_ack", 0, 32'(s_ack[0]), 32'd1);
        check("t1_err", 0, 32'(s_err[0]), 32'd0);
        idle(0); pack(0, 2, 1'b0, 32'h0);
        tick(1);
        check("t1_ack_one_cycle", 0, 32'(s_ack[0]), 32'd0);

        // read from peripheral 1 with 3 wait states, noise ack on port 3
        req(0, 32'h0100_0000, 32'h0, 1'b0);
        pack(0, 3, 1'b1, 32'h3333_3333);
        tick(4);
        check("t2_waiting", 0, 32'(s_ack[0]), 32'd0);
        check("t2_stb1", 0, 32'(get_stb(0)), 32'h2);
        pack(0, 1, 1'b1, 32'hCAFE_0001); pack(0, 3, 1'b0, 32'h0);
        tick(1);
        check("t2_ack", 0, 32'(s_ack[0]), 32'd1);
        check("t2_datrd", 0, s_datrd[0], 32'hCAFE_0001);
        check("t2_err", 0, 32'(s_err[0]), 32'd0);
        idle(0); pack(0, 1, 1'b0, 32'h0);
        tick(1);
        check("t2_ack_drop", 0, 32'(s_ack[0]), 32'd0);
        check("t2_datrd_hold", 0, s_datrd[0], 32'hCAFE_0001);

        // unmapped index 3 on the 3-port instance
        req(1, 32'h0300_0000, 32'h5555_0000, 1'b1);
        tick(1);
        check("t3_ack", 1, 32'(s_ack[1]), 32'd1);
        check("t3_err", 1, 32'(s_err[1]), 32'd1);
        check("t3_datrd", 1, s_datrd[1], DEAD);
        check("t3_errcnt", 1, 32'(s_cnt[1]), 32'd1);
        check("t3_no_stb", 1, 32'(get_stb(1)), 32'd0);
        idle(1);
        tick(1);
        check("t3_ack_drop", 1, 32'(s_ack[1]), 32'd0);

        // silent peripheral 0 times out after 8 ACTIVE cycles
        req(0, 32'h0000_0000, 32'hAAAA_0000, 1'b1);
        tick(8);
        check("t4_cycle8_waiting", 0, 32'(s_ack[0]), 32'd0);
        check("t4_stb0", 0, 32'(get_stb(0)), 32'h1);
        tick(1);
        check("t4_ack", 0, 32'(s_ack[0]), 32'd1);
        check("t4_err", 0, 32'(s_err[0]), 32'd1);
        check("t4_datrd", 0, s_datrd[0], DEAD);
        check("t4_stb_drop", 0, 32'(get_stb(0)), 32'd0);
        check("t4_errcnt", 0, 32'(s_cnt[0]), 32'd1);
        idle(0);
        tick(1);

        // ack arrives on exactly the 8th ACTIVE cycle: ack wins
        req(0, 32'h0000_0000, 32'h0, 1'b0);
        tick(8);
        pack(0, 0, 1'b1, 32'h0000_0A08);
        tick(1);
        check("t4b_ack", 0, 32'(s_ack[0]), 32'd1);
        check("t4b_err", 0, 32'(s_err[0]), 32'd0);
        check("t4b_datrd", 0, s_datrd[0], 32'h0000_0A08);
        check("t4b_errcnt", 0, 32'(s_cnt[0]), 32'd1);
        idle(0); pack(0, 0, 1'b0, 32'h0);
        tick(1);

        // master abort in ACTIVE cycle 2, then a late ack
        req(0, 32'h0300_0004, 32'h0, 1'b1);
        tick(2);
        idle(0);
        tick(1);
        check("t5_stb_drop", 0, 32'(get_stb(0)), 32'd0);
        check("t5_no_ack", 0, 32'(s_ack[0]), 32'd0);
        pack(0, 3, 1'b1, 32'h0BAD_0003);
        tick(1);
        check("t5_late_ack_ignored", 0, 32'(s_ack[0]), 32'd0);
        check("t5_errcnt", 0, 32'(s_cnt[0]), 32'd1);
        pack(0, 3, 1'b0, 32'h0);

        // back-to-back on the 3-port instance, cyc held through RESP
        req(1, 32'h0000_0000, 32'h0000_0001, 1'b1);
        tick(1);
        pack(1, 0, 1'b1, 32'h0B0B_0000);
        tick(1);
        check("t6_first_ack", 1, 32'(s_ack[1]), 32'd1);
        req(1, 32'h0100_0000, 32'h0, 1'b0);
        pack(1, 0, 1'b0, 32'h0);
        tick(1);
        check("t6_resp_gap_ack", 1, 32'(s_ack[1]), 32'd0);
        check("t6_resp_gap_stb", 1, 32'(get_stb(1)), 32'd0);
        tick(1);
        check("t6_second_stb", 1, 32'(get_stb(1)), 32'h2);
        pack(1, 1, 1'b1, 32'h0B0B_0001);
        tick(1);
        check("t6_second_ack", 1, 32'(s_ack[1]), 32'd1);
        check("t6_second_datrd", 1, s_datrd[1], 32'h0B0B_0001);
        idle(1); pack(1, 1, 1'b0, 32'h0);
        tick(1);

        // reset during ACTIVE, late ack, then a normal transfer
        req(0, 32'h0200_0000, 32'h0000_0007, 1'b1);
        tick(2);
        rst = 1'b1; idle(0);
        tick(1);
        rst = 1'b0;
        pack(0, 2, 1'b1, 32'h0BAD_0000);
        check("t7_rst_stb", 0, 32'(get_stb(0)), 32'd0);
        check("t7_rst_datrd", 0, s_datrd[0], 32'd0);
        check("t7_rst_errcnt", 0, 32'(s_cnt[0]), 32'd0);
        tick(1);
        check("t7_late_ack_ignored", 0, 32'(s_ack[0]), 32'd0);
        pack(0, 2, 1'b0, 32'h0);
        req(0, 32'h0200_0020, 32'h0000_0009, 1'b1);
        tick(1);
        pack(0, 2, 1'b1, 32'h0000_1111);
        tick(1);
        check("t7_next_ack", 0, 32'(s_ack[0]), 32'd1);
        check("t7_next_err", 0, 32'(s_err[0]), 32'd0);
        check("t7_next_datrd", 0, s_datrd[0], 32'h0000_1111);
        idle(0); pack(0, 2, 1'b0, 32'h0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
